// File: rtl/wb_obi_bridge.sv
// wb_obi_bridge
// Wishbone classic slave to OBI master bridge. One Wishbone transfer is
// accepted at a time. Its address is checked against a window. A hit is
// translated into a single OBI transaction. A miss is answered with err_o.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   cyc_i, stb_i, we_i     Wishbone cycle / strobe / write enable
//   sel_i, adr_i, dat_i    Wishbone byte select, address, write data
//   dat_o, ack_o, err_o    Wishbone read data, acknowledge, window error
//   req_o, gnt_i           OBI request / grant
//   addr_o, we_o, be_o     OBI address, write enable, byte enables
//   wdata_o                OBI write data
//   rvalid_i, rdata_i      OBI response valid / read data
//   busy_o                 a transfer is in flight (FSM not idle)
//   state_o                debug view of the FSM state encoding
//
// Handshakes: an OBI address phase completes on the cycle where req_o and
// gnt_i are both high. req_o is never withdrawn before that cycle, and
// addr_o/we_o/be_o/wdata_o are held constant while req_o is high. The
// response is the first rvalid_i sampled after the grant cycle. An rvalid_i
// in the grant cycle itself is ignored. On the Wishbone side, cyc_i & stb_i
// sampled in IDLE starts a transfer. ack_o or err_o is a single-cycle pulse.
// All other Wishbone inputs except cyc_i are ignored while busy.
module wb_obi_bridge #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    WB_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]    WIN_MASK = 32'hFF00_0000,
  parameter logic [ADDR_W-1:0]    OBI_BASE = 32'h8000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   sel_i,
  input  logic [ADDR_W-1:0]     adr_i,
  input  logic [DATA_W-1:0]     dat_i,
  output logic [DATA_W-1:0]     dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [ADDR_W-1:0]     addr_o,
  output logic                  we_o,
  output logic [DATA_W/8-1:0]   be_o,
  output logic [DATA_W-1:0]     wdata_o,
  input  logic                  rvalid_i,
  input  logic [DATA_W-1:0]     rdata_i,
  output logic                  busy_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RSP  = 3'd2,
    ACK  = 3'd3,
    ERR  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic                abort_q, abort_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                win_hit;

  assign win_hit = ((adr_i & WIN_MASK) == (WB_BASE & WIN_MASK));

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    abort_d = abort_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        // While ack_o is high the master still holds stb_i for the transfer
        // just acknowledged; that strobe must not start a duplicate.
        if (cyc_i && stb_i && !ack_q) begin
          we_d    = we_i;
          be_d    = sel_i;
          wdata_d = dat_i;
          addr_d  = OBI_BASE | (adr_i & ~WIN_MASK);
          if (win_hit) begin
            state_d = REQ;
            req_d   = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (!cyc_i) abort_d = 1'b1;
        if (gnt_i) begin
          req_d   = 1'b0;
          state_d = RSP;
        end
      end
      RSP: begin
        if (!cyc_i) abort_d = 1'b1;
        if (rvalid_i) begin
          if (!we_q) dat_d = rdata_i;
          state_d = ACK;
        end
      end
      ACK: begin
        // The OBI side has completed; an abandoned Wishbone cycle sees no ack.
        ack_d   = !abort_q;
        abort_d = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      abort_q <= abort_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dat_q   <= dat_d;
    end
  end

  assign dat_o   = dat_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign req_o   = req_q;
  assign addr_o  = addr_q;
  assign we_o    = we_q;
  assign be_o    = be_q;
  assign wdata_o = wdata_q;
  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_wb_obi_bridge.sv
// Testbench for wb_obi_bridge. Transfers are described by their timing
// parameters: grant delay g, response delay r, and an optional abort cycle.
// The expected waveform of every output is derived from those parameters as
// absolute edge windows. It is checked on every cycle by one compare process.
module tb_wb_obi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic [31:0] adr_i = '0, dat_i = '0;
  logic [31:0] dat_o;
  logic        ack_o, err_o, req_o, we_o, busy_o;
  logic        gnt_i = 1'b0, rvalid_i = 1'b0;
  logic [31:0] addr_o, wdata_o;
  logic [31:0] rdata_i = '0;
  logic [3:0]  be_o;
  logic [2:0]  state_o;

  wb_obi_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .busy_o(busy_o), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_miss = 0;
  int edge_cnt = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model state ----------------
  localparam logic [31:0] WIN_MASK = 32'hFF00_0000;
  localparam logic [31:0] WB_BASE  = 32'h0000_0000;
  localparam logic [31:0] OBI_BASE = 32'h8000_0000;

  int          m_n = -100, m_g = 0, m_r = 1;
  bit          m_hit = 1'b0, m_ab = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_dat_cur = '0, m_dat_new = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = '0;

  // observations used by the literal checks
  int          req_cnt, ack_cnt, err_cnt, ack_edge, err_edge;
  logic [31:0] obs_addr, obs_wdata, obs_dat;
  logic [3:0]  obs_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic clear_obs();
    req_cnt = 0; ack_cnt = 0; err_cnt = 0; ack_edge = -1; err_edge = -1;
    obs_addr = '0; obs_wdata = '0; obs_dat = '0; obs_be = '0;
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk_i) begin
    int  e;
    bit  x_req, x_ack, x_err, x_busy;
    logic [31:0] x_dat;
    edge_cnt = edge_cnt + 1;
    #1;
    e = edge_cnt;
    if (req_o) begin req_cnt++; obs_addr = addr_o; obs_wdata = wdata_o; obs_be = be_o; end
    if (ack_o) begin ack_cnt++; ack_edge = e; obs_dat = dat_o; end
    if (err_o) begin err_cnt++; err_edge = e; end
    if (chk_en) begin
      x_req  = m_hit && (e >= m_n) && (e <= m_n + m_g);
      x_ack  = m_hit && !m_ab && (e == m_n + m_g + m_r + 2);
      x_err  = !m_hit && (e == m_n);
      x_busy = m_hit ? ((e >= m_n) && (e <= m_n + m_g + m_r + 1)) : (e == m_n);
      x_dat  = (m_hit && (e >= m_n + m_g + m_r + 1)) ? m_dat_new : m_dat_cur;
      check("req_o",  32'(req_o),  32'(x_req));
      check("ack_o",  32'(ack_o),  32'(x_ack));
      check("err_o",  32'(err_o),  32'(x_err));
      check("busy_o", 32'(busy_o), 32'(x_busy));
      check("dat_o",  dat_o, x_dat);
      if (x_req) begin
        check("addr_o",  addr_o,      m_addr);
        check("we_o",    32'(we_o),   32'(m_we));
        check("be_o",    32'(be_o),   32'(m_be));
        check("wdata_o", wdata_o,     m_wdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One Wishbone transfer with its OBI responder. g = grant delay in cycles,
  // r = cycles from grant to rvalid (>=1), ab = abort cycle offset (<0 none),
  // spur = also pulse rvalid in the grant cycle (must be ignored).
  task automatic do_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input int g, input int r, input int ab,
                         input logic [31:0] rd, input bit spur);
    int n, k, last;
    bit hit;
    @(negedge clk_i);
    n   = edge_cnt + 1;
    hit = ((adr & WIN_MASK) == (WB_BASE & WIN_MASK));
    m_dat_cur = m_dat_new;
    m_dat_new = (hit && !we) ? rd : m_dat_cur;
    m_n = n; m_g = g; m_r = r; m_hit = hit; m_ab = hit && (ab >= 0);
    m_addr = OBI_BASE | (adr & ~WIN_MASK);
    m_we = we; m_be = sel; m_wdata = dat;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; sel_i = sel; adr_i = adr; dat_i = dat;
    gnt_i = 1'b0; rvalid_i = 1'b0;
    last = hit ? (n + g + r + 2) : n;
    while (edge_cnt < last) begin
      @(negedge clk_i);
      k = edge_cnt;
      gnt_i    = hit && (k == n + g);
      rvalid_i = hit && ((k == n + g + r) || (spur && (k == n + g)));
      rdata_i  = (k == n + g + r) ? rd : ((k == n + g) ? ~rd : $urandom);
      if (ab >= 0 && k == n + ab) begin cyc_i = 1'b0; stb_i = 1'b0; end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk_i);
      cyc_i = 1'b0; stb_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_obs();
    repeat (3) @(negedge clk_i);
    check("rst_req",   32'(req_o),  32'd0);
    check("rst_ack",   32'(ack_o),  32'd0);
    check("rst_err",   32'(err_o),  32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_addr",  addr_o,      32'd0);
    check("rst_dat",   dat_o,       32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // single write, minimum latency
    clear_obs();
    do_xfer(32'h0000_0040, 1'b1, 4'hF, 32'hA5A5_1234, 0, 1, -1, 32'h0, 1'b0);
    check("wr_addr",  obs_addr,  32'h8000_0040);
    check("wr_wdata", obs_wdata, 32'hA5A5_1234);
    check("wr_be",    32'(obs_be), 32'hF);
    check("wr_reqs",  32'(req_cnt), 32'd1);
    check("wr_acks",  32'(ack_cnt), 32'd1);
    check("wr_lat",   32'(ack_edge - m_n), 32'd3);
    idle(2);

    // read with stalls
    clear_obs();
    do_xfer(32'h0012_3450, 1'b0, 4'hF, 32'h0, 3, 2, -1, 32'hCAFE_F00D, 1'b0);
    check("rd_addr", obs_addr, 32'h8012_3450);
    check("rd_reqs", 32'(req_cnt), 32'd4);
    check("rd_data", obs_dat, 32'hCAFE_F00D);
    check("rd_acks", 32'(ack_cnt), 32'd1);
    idle(1);

    // out of window
    clear_obs();
    do_xfer(32'h0100_0000, 1'b0, 4'hF, 32'h0, 0, 1, -1, 32'h0, 1'b0);
    check("oow_errs", 32'(err_cnt), 32'd1);
    check("oow_lat",  32'(err_edge - m_n), 32'd0);
    check("oow_reqs", 32'(req_cnt), 32'd0);
    check("oow_acks", 32'(ack_cnt), 32'd0);
    idle(2);

    // abort while waiting for grant, then a normal transfer
    clear_obs();
    do_xfer(32'h0000_0200, 1'b0, 4'hF, 32'h0, 3, 1, 1, 32'h1357_9BDF, 1'b0);
    check("ab_reqs", 32'(req_cnt), 32'd4);
    check("ab_acks", 32'(ack_cnt), 32'd0);
    idle(1);
    check("ab_busy", 32'(busy_o), 32'd0);
    clear_obs();
    do_xfer(32'h0000_0204, 1'b1, 4'hF, 32'h0BAD_CAFE, 1, 1, -1, 32'h0, 1'b0);
    check("ab_next_acks", 32'(ack_cnt), 32'd1);
    idle(1);

    // byte write, then back-to-back transfers
    clear_obs();
    do_xfer(32'h0000_0010, 1'b1, 4'b0010, 32'h0000_AB00, 0, 1, -1, 32'h0, 1'b0);
    check("byte_be", 32'(obs_be), 32'b0010);
    clear_obs();
    do_xfer(32'h00AB_CD00, 1'b0, 4'hF, 32'h0, 0, 1, -1, 32'h2468_ACE0, 1'b0);
    do_xfer(32'h00AB_CD04, 1'b1, 4'h3, 32'h1111_2222, 0, 1, -1, 32'h0, 1'b0);
    check("b2b_reqs", 32'(req_cnt), 32'd2);
    check("b2b_acks", 32'(ack_cnt), 32'd2);
    check("b2b_addr", obs_addr, 32'h80AB_CD04);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [31:0] adr;
      int g, r, ab;
      adr = $urandom;
      if ($urandom_range(0, 3) != 0) adr[31:24] = 8'h00;
      else if (adr[31:24] == 8'h00) adr[31:24] = 8'h5A;
      g  = $urandom_range(0, 3);
      r  = $urandom_range(1, 3);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, g + r) : -1;
      do_xfer(adr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
              g, r, ab, $urandom, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    // reset during the response phase
    do_xfer(32'h0000_0300, 1'b0, 4'hF, 32'h0, 0, 1, -1, 32'h1234_5678, 1'b0);
    idle(1);
    chk_en = 1'b0;
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h0000_0100; sel_i = 4'hF;
    @(negedge clk_i); gnt_i = 1'b1;
    @(negedge clk_i); gnt_i = 1'b0;
    @(negedge clk_i);
    check("mid_busy", 32'(busy_o), 32'd1);
    check("mid_dat",  dat_o, 32'h1234_5678);
    rst_ni = 1'b0;
    #1;
    check("arst_req",  32'(req_o),  32'd0);
    check("arst_ack",  32'(ack_o),  32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_dat",  dat_o,       32'd0);
    check("arst_addr", addr_o,      32'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    clear_obs();
    @(negedge clk_i); rvalid_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i); rvalid_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("post_busy",  32'(busy_o),  32'd0);
      check("post_state", 32'(state_o), 32'd0);
      check("post_dat",   dat_o,        32'd0);
    end
    check("post_acks", 32'(ack_cnt), 32'd0);
    m_hit = 1'b0; m_ab = 1'b0; m_n = -100; m_dat_cur = '0; m_dat_new = '0;
    chk_en = 1'b1;
    clear_obs();
    do_xfer(32'h0000_0400, 1'b0, 4'hF, 32'h0, 1, 2, -1, 32'h7777_8888, 1'b0);
    check("rec_data", obs_dat, 32'h7777_8888);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
